// File: rtl/block_move_ctrl.sv
// rtl/block_move_ctrl.sv - piece movement controller: candidate generation, collision check, commit, lock and respawn
module block_move_ctrl #(
    parameter int BOARD_W     = 20,
    parameter int BOARD_H     = 30,
    parameter int ROT_STATES  = 4,
    parameter int SPAWN_X     = 9,
    parameter int CHK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic       tick,
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  logic [9:0] cur_rot,
    output logic [9:0] cand_x,
    output logic [9:0] cand_y,
    output logic [9:0] cand_rot,
    output logic       chk_req,
    input  logic       chk_done,
    input  logic       chk_hit,
    output logic       pos_refresh,
    output logic       pos_err,
    output logic       lock,
    input  logic       lock_done,
    output logic       game_over,
    output logic       busy
);

    localparam logic [9:0] X_MAX    = 10'(BOARD_W - 1);
    localparam logic [9:0] Y_MAX    = 10'(BOARD_H - 1);
    localparam logic [9:0] ROT_LAST = 10'(ROT_STATES - 1);
    localparam logic [9:0] SPAWN_XV = 10'(SPAWN_X);
    localparam int         CNT_W    = $clog2(CHK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COMMIT,
        S_LOCK,
        S_SPAWN,
        S_SPAWN_CHK,
        S_OVER
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_FALL,
        EV_ROT,
        EV_LEFT,
        EV_RIGHT
    } ev_t;

    state_t           state;
    state_t           state_next;
    ev_t              ev;
    logic [9:0]       ev_x;
    logic [9:0]       ev_y;
    logic [9:0]       ev_rot;
    logic [9:0]       cand_x_q;
    logic [9:0]       cand_y_q;
    logic [9:0]       cand_rot_q;
    logic             is_fall;
    logic             pend_tick;
    logic [CNT_W-1:0] wait_cnt;
    logic             chk_expired;
    logic             in_chk;

    assign in_chk      = (state == S_CHECK) || (state == S_SPAWN_CHK);
    assign chk_expired = (wait_cnt == CNT_LAST);

    // Pick the single highest-priority event and form its candidate from cur_*
    always_comb begin
        ev     = EV_NONE;
        ev_x   = cur_x;
        ev_y   = cur_y;
        ev_rot = cur_rot;
        if (tick || pend_tick || btn_down) begin
            ev   = EV_FALL;
            ev_y = cur_y + 10'd1;
        end else if (btn_rot) begin
            ev     = EV_ROT;
            ev_rot = (cur_rot >= ROT_LAST) ? 10'd0 : cur_rot + 10'd1;
        end else if (btn_left) begin
            ev   = EV_LEFT;
            ev_x = cur_x - 10'd1;
        end else if (btn_right) begin
            ev   = EV_RIGHT;
            ev_x = cur_x + 10'd1;
        end
    end

    // State register; reset wins over any transition at the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                case (ev)
                    EV_FALL:  state_next = (cur_y == Y_MAX) ? S_LOCK : S_CHECK;
                    EV_ROT:   state_next = S_CHECK;
                    EV_LEFT:  state_next = (cur_x == 10'd0) ? S_IDLE : S_CHECK;
                    EV_RIGHT: state_next = (cur_x == X_MAX) ? S_IDLE : S_CHECK;
                    default:  state_next = S_IDLE;
                endcase
            end
            S_CHECK: begin
                if (chk_done && !chk_hit) begin
                    state_next = S_COMMIT;
                end else if (chk_done || chk_expired) begin
                    // an unanswered check is treated the same as a collision
                    state_next = is_fall ? S_LOCK : S_IDLE;
                end
            end
            S_COMMIT:    state_next = S_IDLE;
            S_LOCK:      state_next = lock_done ? S_SPAWN : S_LOCK;
            S_SPAWN:     state_next = S_SPAWN_CHK;
            S_SPAWN_CHK: begin
                if (chk_done && !chk_hit) begin
                    state_next = S_IDLE;
                end else if (chk_done || chk_expired) begin
                    state_next = S_OVER;
                end
            end
            S_OVER:      state_next = S_OVER;
            default:     state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        chk_req     = 1'b0;
        pos_refresh = 1'b0;
        pos_err     = 1'b0;
        lock        = 1'b0;
        game_over   = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE:      busy        = 1'b0;
            S_CHECK:     chk_req     = 1'b1;
            S_COMMIT:    pos_refresh = 1'b1;
            S_LOCK:      lock        = 1'b1;
            S_SPAWN:     pos_err     = 1'b1;
            S_SPAWN_CHK: chk_req     = 1'b1;
            S_OVER: begin
                game_over = 1'b1;
                busy      = 1'b0;
            end
            default:     busy        = 1'b0;
        endcase
    end

    assign cand_x   = cand_x_q;
    assign cand_y   = cand_y_q;
    assign cand_rot = cand_rot_q;

    // Candidate latch, fall flag, pending gravity tick and check timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_x_q   <= 10'd0;
            cand_y_q   <= 10'd0;
            cand_rot_q <= 10'd0;
            is_fall    <= 1'b0;
            pend_tick  <= 1'b0;
            wait_cnt   <= CNT_ONE;
        end else begin
            // the counter idles at 1 so the first request cycle already reads 1
            wait_cnt <= in_chk ? wait_cnt + CNT_ONE : CNT_ONE;

            if (state == S_IDLE) begin
                // a pending tick always has top priority in IDLE, so it is serviced here
                pend_tick <= 1'b0;
                if (state_next != S_IDLE) begin
                    cand_x_q   <= ev_x;
                    cand_y_q   <= ev_y;
                    cand_rot_q <= ev_rot;
                    is_fall    <= (ev == EV_FALL);
                end
            end else if (state != S_OVER && tick) begin
                pend_tick <= 1'b1;
            end

            if (state == S_SPAWN) begin
                cand_x_q   <= SPAWN_XV;
                cand_y_q   <= 10'd0;
                cand_rot_q <= 10'd0;
                is_fall    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_block_move_ctrl.sv
// tb/tb_block_move_ctrl.sv - scoreboard bench for block_move_ctrl
module tb_block_move_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_left, btn_right, btn_rot, btn_down, tick;
    logic [9:0] cur_x, cur_y, cur_rot;
    logic [9:0] cand_x, cand_y, cand_rot;
    logic       chk_req, chk_done, chk_hit;
    logic       pos_refresh, pos_err, lock, lock_done, game_over, busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_refresh = 0;
    int          n_err     = 0;
    int          n_req     = 0;
    logic        prev_req  = 1'b0;
    logic [29:0] sb[$];
    logic [29:0] exp_c;

    block_move_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
        .tick(tick),
        .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot),
        .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot),
        .chk_req(chk_req), .chk_done(chk_done), .chk_hit(chk_hit),
        .pos_refresh(pos_refresh), .pos_err(pos_err),
        .lock(lock), .lock_done(lock_done),
        .game_over(game_over), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles and request starts
    always @(posedge clk) begin
        if (pos_refresh === 1'b1) n_refresh++;
        if (pos_err === 1'b1) n_err++;
        if (chk_req === 1'b1 && prev_req !== 1'b1) n_req++;
        prev_req = chk_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_cur(input int x, input int y, input int r);
        cur_x = 10'(x); cur_y = 10'(y); cur_rot = 10'(r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_checks++; if ({chk_req, pos_refresh, pos_err, lock, game_over, busy} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=000000", {chk_req, pos_refresh, pos_err, lock, game_over, busy}); end
        n_checks++; if ({cand_x, cand_y, cand_rot} !== 30'd0) begin
            n_fail++; $display("FAIL reset_cand got=%0h exp=0", {cand_x, cand_y, cand_rot}); end
        rst_n = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_clear_move();
        int r0;
        set_cur(5, 3, 0); r0 = n_refresh;
        sb.push_back({10'd4, 10'd3, 10'd0});
        btn_left = 1'b1; step(); btn_left = 1'b0;
        n_checks++; if (chk_req !== 1'b1) begin n_fail++; $display("FAIL clear_req got=%b exp=1", chk_req); end
        exp_c = sb.pop_front();
        n_checks++; if ({cand_x, cand_y, cand_rot} !== exp_c) begin
            n_fail++; $display("FAIL clear_cand got=%0h exp=%0h", {cand_x, cand_y, cand_rot}, exp_c); end
        step();
        chk_done = 1'b1; chk_hit = 1'b0; step(); chk_done = 1'b0;
        n_checks++; if ({pos_refresh, chk_req} !== 2'b10) begin
            n_fail++; $display("FAIL clear_commit refresh,req got=%b exp=10", {pos_refresh, chk_req}); end
        n_checks++; if ({cand_x, cand_y, cand_rot} !== exp_c) begin
            n_fail++; $display("FAIL clear_cand_held got=%0h exp=%0h", {cand_x, cand_y, cand_rot}, exp_c); end
        set_cur(4, 3, 0); step();
        n_checks++; if ({pos_refresh, busy} !== 2'b00) begin
            n_fail++; $display("FAIL clear_idle refresh,busy got=%b exp=00", {pos_refresh, busy}); end
        n_checks++; if (n_refresh - r0 !== 1) begin
            n_fail++; $display("FAIL clear_refresh_count got=%0d exp=1", n_refresh - r0); end
    endtask

    task automatic test_bounds();
        int q0, r0;
        q0 = n_req; r0 = n_refresh;
        set_cur(0, 3, 0);
        btn_left = 1'b1; step(); btn_left = 1'b0; step(); step();
        set_cur(19, 3, 0);
        btn_right = 1'b1; step(); btn_right = 1'b0; step(); step();
        n_checks++; if (n_req - q0 !== 0) begin n_fail++; $display("FAIL bounds_req got=%0d exp=0", n_req - q0); end
        n_checks++; if (n_refresh - r0 !== 0) begin n_fail++; $display("FAIL bounds_refresh got=%0d exp=0", n_refresh - r0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bounds_busy got=%b exp=0", busy); end
        // rotate from the last state wraps to 0; a hit returns to IDLE without refresh
        set_cur(7, 5, 3);
        sb.push_back({10'd7, 10'd5, 10'd0});
        btn_rot = 1'b1; step(); btn_rot = 1'b0;
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL rot_wrap got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        chk_done = 1'b1; chk_hit = 1'b1; step(); chk_done = 1'b0; chk_hit = 1'b0;
        n_checks++; if ({busy, lock, pos_refresh} !== 3'b000) begin
            n_fail++; $display("FAIL rot_hit_idle busy,lock,refresh got=%b exp=000", {busy, lock, pos_refresh}); end
        step();
        n_checks++; if (n_refresh - r0 !== 0) begin n_fail++; $display("FAIL rot_hit_refresh got=%0d exp=0", n_refresh - r0); end
    endtask

    task automatic test_blocked_fall();
        int e0;
        e0 = n_err;
        set_cur(9, 10, 1);
        sb.push_back({10'd9, 10'd11, 10'd1});
        sb.push_back({10'd9, 10'd0, 10'd0});
        tick = 1'b1; step(); tick = 1'b0;
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL fall_cand got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        chk_done = 1'b1; chk_hit = 1'b1; step(); chk_done = 1'b0; chk_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({lock, chk_req} !== 2'b10) begin
                n_fail++; $display("FAIL fall_lock_hold cycle=%0d lock,req got=%b exp=10", i, {lock, chk_req}); end
            step();
        end
        lock_done = 1'b1; step(); lock_done = 1'b0;
        n_checks++; if ({lock, pos_err} !== 2'b01) begin
            n_fail++; $display("FAIL fall_pos_err lock,err got=%b exp=01", {lock, pos_err}); end
        set_cur(9, 0, 0); step();
        exp_c = sb.pop_front();
        n_checks++; if ({pos_err, chk_req, cand_x, cand_y, cand_rot} !== {2'b01, exp_c}) begin
            n_fail++; $display("FAIL spawn_chk got=%0h exp=%0h", {pos_err, chk_req, cand_x, cand_y, cand_rot}, {2'b01, exp_c}); end
        chk_done = 1'b1; chk_hit = 1'b0; step(); chk_done = 1'b0;
        n_checks++; if ({busy, game_over} !== 2'b00) begin
            n_fail++; $display("FAIL spawn_clear busy,over got=%b exp=00", {busy, game_over}); end
        n_checks++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL pos_err_count got=%0d exp=1", n_err - e0); end
    endtask

    task automatic test_game_over();
        int q0;
        q0 = n_req;
        set_cur(9, 29, 0);
        sb.push_back({10'd9, 10'd0, 10'd0});
        tick = 1'b1; step(); tick = 1'b0;
        n_checks++; if ({lock, chk_req} !== 2'b10 || n_req - q0 !== 0) begin
            n_fail++; $display("FAIL bottom_lock lock,req got=%b reqs=%0d exp=10 reqs=0", {lock, chk_req}, n_req - q0); end
        lock_done = 1'b1; step(); lock_done = 1'b0;
        set_cur(9, 0, 0); step();
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL over_spawn_chk got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        chk_done = 1'b1; chk_hit = 1'b1; step(); chk_done = 1'b0; chk_hit = 1'b0;
        n_checks++; if ({game_over, busy} !== 2'b10) begin
            n_fail++; $display("FAIL over_set over,busy got=%b exp=10", {game_over, busy}); end
        q0 = n_req;
        tick = 1'b1; btn_left = 1'b1; btn_rot = 1'b1; step();
        tick = 1'b0; btn_left = 1'b0; btn_rot = 1'b0; btn_down = 1'b1; step(); btn_down = 1'b0;
        repeat (4) step();
        n_checks++; if (n_req - q0 !== 0 || game_over !== 1'b1) begin
            n_fail++; $display("FAIL over_sticky reqs=%0d over=%b exp reqs=0 over=1", n_req - q0, game_over); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_checks++; if ({game_over, busy, chk_req} !== 3'b000) begin
            n_fail++; $display("FAIL over_reset got=%b exp=000", {game_over, busy, chk_req}); end
        step();
    endtask

    task automatic test_priority();
        set_cur(5, 3, 0);
        sb.push_back({10'd5, 10'd4, 10'd0});
        tick = 1'b1; btn_rot = 1'b1; step(); tick = 1'b0; btn_rot = 1'b0;
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL prio_cand got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        chk_done = 1'b1; chk_hit = 1'b0; step(); chk_done = 1'b0;
        set_cur(5, 4, 0); step();
        step();
        n_checks++; if ({busy, chk_req} !== 2'b00) begin
            n_fail++; $display("FAIL prio_no_rot busy,req got=%b exp=00", {busy, chk_req}); end
    endtask

    task automatic test_pending();
        sb.push_back({10'd6, 10'd4, 10'd0});
        sb.push_back({10'd6, 10'd5, 10'd0});
        btn_right = 1'b1; step(); btn_right = 1'b0;
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL pend_first got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        tick = 1'b1; step(); tick = 1'b0;
        chk_done = 1'b1; chk_hit = 1'b0; step(); chk_done = 1'b0;
        n_checks++; if (pos_refresh !== 1'b1) begin n_fail++; $display("FAIL pend_commit got=%b exp=1", pos_refresh); end
        set_cur(6, 4, 0); step();
        n_checks++; if ({busy, chk_req} !== 2'b00) begin
            n_fail++; $display("FAIL pend_idle busy,req got=%b exp=00", {busy, chk_req}); end
        step();
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL pend_second got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        chk_done = 1'b1; chk_hit = 1'b0; step(); chk_done = 1'b0;
        set_cur(6, 5, 0); step(); step(); step();
        n_checks++; if ({busy, chk_req} !== 2'b00) begin
            n_fail++; $display("FAIL pend_cleared busy,req got=%b exp=00", {busy, chk_req}); end
    endtask

    task automatic test_timeout();
        int r0, n;
        r0 = n_refresh;
        set_cur(5, 5, 0);
        sb.push_back({10'd6, 10'd5, 10'd0});
        btn_right = 1'b1; step(); btn_right = 1'b0;
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL tmo_cand got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        n = 0;
        while (chk_req === 1'b1 && n < 40) begin n++; step(); end
        n_checks++; if (n !== 15) begin n_fail++; $display("FAIL tmo_req_cycles got=%0d exp=15", n); end
        n_checks++; if ({busy, lock} !== 2'b00) begin
            n_fail++; $display("FAIL tmo_idle busy,lock got=%b exp=00", {busy, lock}); end
        step();
        n_checks++; if (n_refresh - r0 !== 0) begin n_fail++; $display("FAIL tmo_refresh got=%0d exp=0", n_refresh - r0); end
    endtask

    task automatic test_reset_mid_check();
        sb.push_back({10'd4, 10'd5, 10'd0});
        btn_left = 1'b1; step(); btn_left = 1'b0;
        exp_c = sb.pop_front();
        n_checks++; if ({chk_req, cand_x, cand_y, cand_rot} !== {1'b1, exp_c}) begin
            n_fail++; $display("FAIL rstmid_cand got=%0h exp=%0h", {chk_req, cand_x, cand_y, cand_rot}, {1'b1, exp_c}); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_checks++; if ({chk_req, busy, cand_x} !== 12'd0) begin
            n_fail++; $display("FAIL rstmid got=%0h exp=0", {chk_req, busy, cand_x}); end
        step();
    endtask

    initial begin
        rst_n = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_down = 1'b0;
        tick = 1'b0; chk_done = 1'b0; chk_hit = 1'b0; lock_done = 1'b0;
        set_cur(0, 0, 0);
        step();
        test_reset();
        test_clear_move();
        test_bounds();
        test_blocked_fall();
        test_game_over();
        test_priority();
        test_pending();
        test_timeout();
        test_reset_mid_check();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_move_ctrl.md
# block_move_ctrl

Movement controller that sits directly upstream of the block position register. It turns player button pulses and the gravity tick into candidate (x, y, rotate) positions and asks the board collision checker to validate each one. A clear candidate is committed with a one-cycle refresh strobe; a blocked fall locks the piece and respawns it through the position register's error/reset input. A spawn collision raises sticky game over.

## Interface
Parameters:
- BOARD_W, 20, board width in cells; legal x is 0..BOARD_W-1
- BOARD_H, 30, board height in cells; legal y is 0..BOARD_H-1
- ROT_STATES, 4, number of rotation states; rotate wraps modulo this
- SPAWN_X, 9, spawn column; must match the position register's reset x
- CHK_TIMEOUT, 15, maximum cycles to wait for chk_done

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- btn_left, btn_right, btn_rot, btn_down  in  1 each  one-cycle debounced pulses
- tick  in  1  one-cycle gravity pulse
- cur_x, cur_y, cur_rot  in  10 each  current position from the position register
- cand_x, cand_y, cand_rot  out  10 each  candidate position; feeds the checker and the register's *_in ports
- chk_req  out  1  collision check request
- chk_done  in  1  checker result valid
- chk_hit  in  1  candidate collides; qualified by chk_done
- pos_refresh  out  1  one-cycle load strobe to the position register
- pos_err  out  1  one-cycle respawn strobe; register resets to (SPAWN_X, 0, 0)
- lock  out  1  request to write the piece into the board
- lock_done  in  1  board write complete
- game_over  out  1  sticky until reset
- busy  out  1  high in every state except IDLE and OVER

## Operation
States: IDLE, CHECK, COMMIT, LOCK, SPAWN, SPAWN_CHK, OVER.

- **Reset:** state is IDLE. All strobes are 0: chk_req, pos_refresh, pos_err, lock, game_over, busy. cand_* is 0. The pending-tick flag is cleared.
- **IDLE event priority:** pending or current tick first, then btn_down, then btn_rot, then btn_left, then btn_right. Only one event is accepted per cycle. Lower-priority events in the same cycle are dropped.
- **Candidate forms:**
  - fall (tick or down): (cur_x, cur_y+1, cur_rot)
  - rotate: (cur_x, cur_y, (cur_rot+1) mod ROT_STATES); the wrap is 3 -> 0
  - left: (cur_x-1, cur_y, cur_rot)
  - right: (cur_x+1, cur_y, cur_rot)
  - All arithmetic is 10-bit unsigned.
- **Bounds pre-check (no chk_req issued):**
  - left with cur_x == 0: event discarded, stay in IDLE.
  - right with cur_x == BOARD_W-1: event discarded, stay in IDLE.
  - fall with cur_y == BOARD_H-1: go directly to LOCK.
- **CHECK:**
  - Hold chk_req and stable cand_* until chk_done.
  - chk_done with !chk_hit: go to COMMIT.
  - chk_done with chk_hit: a fall goes to LOCK; any other move returns to IDLE with no refresh.
  - No chk_done within CHK_TIMEOUT cycles counts as a hit.
- **COMMIT:** pos_refresh is high for 1 cycle with cand_* held, then IDLE.
- **LOCK:** hold lock until lock_done, then SPAWN.
- **SPAWN:** pos_err is high for 1 cycle, then SPAWN_CHK.
- **SPAWN_CHK:** cand_* = (SPAWN_X, 0, 0) and chk_req is asserted. A clear result goes to IDLE. A hit or timeout goes to OVER.
- **OVER:** game_over = 1. All inputs are ignored; only rst_n exits.
- **Pending tick:**
  - A tick arriving while the state is neither IDLE nor OVER sets a one-deep pending flag.
  - Further ticks while the flag is set are absorbed.
  - The flag is cleared when the tick is serviced from IDLE.
  - Buttons arriving outside IDLE are dropped.

## Timing
- An event sampled in IDLE at edge N gives chk_req high from cycle N+1.
- chk_done is sampled only while chk_req is high. It may arrive in the first request cycle.
- chk_done clear at cycle K gives pos_refresh in cycle K+1 and IDLE at K+2. cur_* is valid by K+2.
- chk_req drops the cycle after chk_done. The timeout counter starts at 1 in the first chk_req cycle.
- lock drops the cycle after lock_done. pos_err fires the following cycle, and chk_req for the spawn check starts the cycle after that.
- rst_n low mid-operation has priority over every transition at that edge. Outputs take reset values on the next edge and the pending tick is lost.

## Test plan
- **Clear move:** cur = (5,3,0), btn_left, chk_done = 1 and chk_hit = 0 two cycles later -> cand = (4,3,0), a single pos_refresh pulse, return to IDLE.
- **Bounds and rotate wrap:**
  - cur_x = 0 with btn_left -> no chk_req, no refresh.
  - cur_x = 19 with btn_right -> same.
  - cur_rot = 3 with btn_rot -> cand_rot = 0.
- **Blocked fall:** tick at cur = (9,10,1), chk_hit = 1 -> lock held until lock_done, then one pos_err pulse, then spawn chk_req with cand = (9,0,0); clear -> IDLE with game_over = 0.
- **Game over:** spawn check returns a hit -> game_over = 1 sticky; a later tick or buttons produce no chk_req; rst_n low for 1 cycle clears it.
- **Priority and pending:** tick and btn_rot in the same IDLE cycle -> fall candidate only. A tick during CHECK -> a second fall check starts right after returning to IDLE.
- **Timeout and reset:** no chk_done for 15 cycles on a right move -> IDLE with no refresh. rst_n low mid-CHECK -> chk_req = 0 and busy = 0 next cycle.
